// File: rtl/spi_fram_streamer.sv
// Purpose: reads a burst of bytes from an SPI FRAM (READ 0x03) and streams them out over an 8N1 UART, ending with a newline.
// Latency: CS_n falls 1 cycle after accept; per byte 16*SPI_DIV + 10*BAUD_DIV cycles (20*BAUD_DIV in hex mode); done follows the EOL frame.
// Backpressure: none; a start strobe while busy is dropped, and the UART line is paced only by BAUD_DIV.
//
// Ports:
//   clk, rst              : clock and synchronous active-high reset
//   start, addr, len      : job request; addr/len captured on the accepted strobe
//   spi_miso/sclk/mosi/cs_n : SPI mode-0 master towards the FRAM
//   uart_tx               : 8N1 serial output, idle high
//   busy, done            : job in flight / one-cycle completion pulse
// Option: define SPI_FRAM_STREAMER_HEX_ASCII_EN to send each byte as two uppercase ASCII hex characters.

module spi_fram_streamer #(
    parameter int ADDR_BYTES = 2,
    parameter int LEN_W      = 8,
    parameter int SPI_DIV    = 2,
    parameter int BAUD_DIV   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [8*ADDR_BYTES-1:0] addr,
    input  logic [LEN_W-1:0]        len,
    input  logic                    spi_miso,
    output logic                    spi_sclk,
    output logic                    spi_mosi,
    output logic                    spi_cs_n,
    output logic                    uart_tx,
    output logic                    busy,
    output logic                    done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMD  = 3'd1;
    localparam logic [2:0] S_RECV = 3'd2;
    localparam logic [2:0] S_TX   = 3'd3;
    localparam logic [2:0] S_EOL  = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    localparam int              SR_W      = 8 * (1 + ADDR_BYTES);
    localparam logic [5:0]      CMD_LAST  = 6'(SR_W - 1);
    localparam logic [15:0]     SPI_LAST  = 16'(SPI_DIV - 1);
    localparam logic [15:0]     BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [7:0]      OPC_READ  = 8'h03;
    localparam logic [7:0]      CHR_LF    = 8'h0A;
    localparam logic [LEN_W-1:0] ONE_L    = LEN_W'(1);

    logic [2:0]       state_q,  state_d;
    logic [SR_W-1:0]  cmd_sr_q, cmd_sr_d;
    logic [7:0]       rx_sr_q,  rx_sr_d;
    logic [LEN_W-1:0] cnt_q,    cnt_d;
    logic [15:0]      div_q,    div_d;
    logic             sclk_q,   sclk_d;
    logic             mosi_q,   mosi_d;
    logic             cs_n_q,   cs_n_d;
    logic [5:0]       bit_q,    bit_d;
    logic [9:0]       frame_q,  frame_d;
    logic [15:0]      baud_q,   baud_d;
    logic [3:0]       ubit_q,   ubit_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic spi_edge, spi_rise, spi_fall, frame_end;

`ifdef SPI_FRAM_STREAMER_HEX_ASCII_EN
    logic       lo_pend_q, lo_pend_d;
    logic [3:0] lo_nib_q,  lo_nib_d;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction
`endif

    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_n_q;
    // frame_q idles all-ones, so its LSB is the (registered) line state.
    assign uart_tx  = frame_q[0];
    assign busy     = busy_q;
    assign done     = done_q;

    assign spi_edge  = (div_q == SPI_LAST);
    assign spi_rise  = spi_edge && !sclk_q;
    assign spi_fall  = spi_edge &&  sclk_q;
    assign frame_end = (baud_q == BAUD_LAST) && (ubit_q == 4'd9);

    always_comb begin
        state_d  = state_q;
        cmd_sr_d = cmd_sr_q;
        rx_sr_d  = rx_sr_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        cs_n_d   = cs_n_q;
        bit_d    = bit_q;
        frame_d  = frame_q;
        baud_d   = baud_q;
        ubit_d   = ubit_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef SPI_FRAM_STREAMER_HEX_ASCII_EN
        lo_pend_d = lo_pend_q;
        lo_nib_d  = lo_nib_q;
`endif

        // SCLK generator: toggles every SPI_DIV cycles while shifting.
        if (state_q == S_CMD || state_q == S_RECV) begin
            if (spi_edge) begin
                div_d  = 16'd0;
                sclk_d = ~sclk_q;
            end else begin
                div_d = div_q + 16'd1;
            end
        end

        // UART bit timer: shift one bit out every BAUD_DIV cycles.
        if (state_q == S_TX || state_q == S_EOL) begin
            if (baud_q == BAUD_LAST) begin
                baud_d  = 16'd0;
                frame_d = {1'b1, frame_q[9:1]};
                ubit_d  = ubit_q + 4'd1;
            end else begin
                baud_d = baud_q + 16'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    cnt_d  = len;
                    if (len == '0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d  = S_CMD;
                        cs_n_d   = 1'b0;
                        cmd_sr_d = {OPC_READ, addr};
                        mosi_d   = OPC_READ[7];
                        div_d    = 16'd0;
                        sclk_d   = 1'b0;
                        bit_d    = 6'd0;
                    end
                end
            end

            S_CMD: begin
                // MOSI advances on the falling edge, so the FRAM sees it settled at the next rise.
                if (spi_fall) begin
                    bit_d    = bit_q + 6'd1;
                    cmd_sr_d = cmd_sr_q << 1;
                    mosi_d   = cmd_sr_q[SR_W-2];
                    if (bit_q == CMD_LAST) begin
                        state_d = S_RECV;
                        mosi_d  = 1'b0;
                        bit_d   = 6'd0;
                    end
                end
            end

            S_RECV: begin
                if (spi_rise) begin
                    rx_sr_d = {rx_sr_q[6:0], spi_miso};
                end
                if (spi_fall) begin
                    bit_d = bit_q + 6'd1;
                    if (bit_q == 6'd7) begin
                        // All 8 bits were captured on earlier rising edges.
                        state_d = S_TX;
                        bit_d   = 6'd0;
                        baud_d  = 16'd0;
                        ubit_d  = 4'd0;
`ifdef SPI_FRAM_STREAMER_HEX_ASCII_EN
                        frame_d   = {1'b1, hex_ascii(rx_sr_q[7:4]), 1'b0};
                        lo_nib_d  = rx_sr_q[3:0];
                        lo_pend_d = 1'b1;
`else
                        frame_d = {1'b1, rx_sr_q, 1'b0};
`endif
                    end
                end
            end

            S_TX: begin
                if (frame_end) begin
                    baud_d = 16'd0;
                    ubit_d = 4'd0;
`ifdef SPI_FRAM_STREAMER_HEX_ASCII_EN
                    if (lo_pend_q) begin
                        frame_d   = {1'b1, hex_ascii(lo_nib_q), 1'b0};
                        lo_pend_d = 1'b0;
                    end else
`endif
                    begin
                        cnt_d = (cnt_q != '0) ? (cnt_q - ONE_L) : cnt_q;
                        if (cnt_q > ONE_L) begin
                            state_d = S_RECV;
                            frame_d = '1;
                            div_d   = 16'd0;
                            sclk_d  = 1'b0;
                            bit_d   = 6'd0;
                        end else begin
                            state_d = S_EOL;
                            cs_n_d  = 1'b1;
                            frame_d = {1'b1, CHR_LF, 1'b0};
                        end
                    end
                end
            end

            S_EOL: begin
                if (frame_end) begin
                    state_d = S_FIN;
                    frame_d = '1;
                    ubit_d  = 4'd0;
                end
            end

            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cmd_sr_q <= '0;
            rx_sr_q  <= '0;
            cnt_q    <= '0;
            div_q    <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            bit_q    <= '0;
            frame_q  <= '1;
            baud_q   <= '0;
            ubit_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_sr_q <= cmd_sr_d;
            rx_sr_q  <= rx_sr_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            cs_n_q   <= cs_n_d;
            bit_q    <= bit_d;
            frame_q  <= frame_d;
            baud_q   <= baud_d;
            ubit_q   <= ubit_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef SPI_FRAM_STREAMER_HEX_ASCII_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_pend_q <= 1'b0;
            lo_nib_q  <= '0;
        end else begin
            lo_pend_q <= lo_pend_d;
            lo_nib_q  <= lo_nib_d;
        end
    end
`endif

endmodule
